// File: rtl/solid_query_arbiter_pkg.sv
// Shared types, map geometry constants and the tile-clamp helper for the
// solid-query arbiter.
package solid_query_arbiter_pkg;

  localparam int COORD_W    = 16;
  localparam int TILE_SHIFT = 3;
  localparam int MAP_TILES  = 16;
  localparam int TILE_W     = 4;
  localparam int SIZE_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SIZE_W-1:0]  w;
    logic [SIZE_W-1:0]  h;
  } solid_query_t;

  // Pixel (non-negative, one bit wider than a coordinate) to tile index,
  // saturating at the last map column/row.
  function automatic logic [TILE_W-1:0] tile_clamp(input logic [COORD_W:0] px);
    logic [COORD_W:0] t;
    t = px >> TILE_SHIFT;
    if (t > (COORD_W+1)'(MAP_TILES - 1)) begin
      tile_clamp = TILE_W'(MAP_TILES - 1);
    end else begin
      tile_clamp = t[TILE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/solid_query_arbiter_if.sv
// Requester-side bus of the solid-query arbiter: packed per-requester boxes,
// accept pulses and the one-hot response.
interface solid_query_arbiter_if
  import solid_query_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*COORD_W-1:0] req_x;
  logic [N_REQ*COORD_W-1:0] req_y;
  logic [N_REQ*SIZE_W-1:0]  req_w;
  logic [N_REQ*SIZE_W-1:0]  req_h;
  logic [N_REQ-1:0]         resp_valid;
  logic                     resp_solid;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h,
    input  req_ready, resp_valid, resp_solid
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h,
    output req_ready, resp_valid, resp_solid
  );
endinterface

// File: rtl/solid_query_arbiter_rr_arbiter.sv
// Generic N-wide round-robin arbiter: lowest set request at or after the
// pointer wins; the pointer moves past the winner only on accept.
module rr_arbiter
  import solid_query_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             accept,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);
  logic [IDX_W-1:0] ptr_r;
  logic             take_s;

  // rotating priority scan starting at the pointer
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    take_s    = 1'b0;
    for (int k = 0; k < N; k++) begin
      int i;
      i         = (int'(ptr_r) + k) % N;
      take_s    = req[i] & ~any;
      grant[i]  = grant[i] | take_s;
      grant_idx = take_s ? IDX_W'(i) : grant_idx;
      any       = any | take_s;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (accept) begin
      ptr_r <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end else begin
      ptr_r <= ptr_r;
    end
  end
endmodule

// File: rtl/solid_query_arbiter.sv
// Shares the tile-map solidity port among N_REQ requesters; each query reads
// the 1, 2 or 4 tiles a box covers. Optional: SOLID_QUERY_EARLY_EXIT_EN.
module solid_query_arbiter
  import solid_query_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  solid_query_arbiter_if.slave q,
  output logic                 map_rd_en,
  output logic [TILE_W-1:0]    map_rd_x,
  output logic [TILE_W-1:0]    map_rd_y,
  input  logic                 map_rd_solid,
  output logic                 busy
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state_r, state_n;
  logic [N_REQ-1:0]   grant_s;
  logic [IDX_W-1:0]   grant_idx_s, owner_r;
  logic               any_s, accept_s;
  solid_query_t       sel_s;
  logic [COORD_W-1:0] x_s, y_s;
  logic [SIZE_W-1:0]  w_s, h_s;
  logic [COORD_W:0]   x_end_s, y_end_s;
  logic [TILE_W-1:0]  tx0_s, tx1_s, ty0_s, ty1_s;
  logic [TILE_W-1:0]  tx0_r, tx1_r, ty0_r, ty1_r;
  logic               multi_x_r, multi_y_r;
  logic [1:0]         idx_r, idx_n, last_idx_s;
  logic               col_s, row_s;
  logic               rd_pend_r, acc_r, acc_n, hit_s, rd_en_s;

  assign accept_s = (state_r == ST_IDLE) && any_s;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (q.req_valid),
    .accept    (accept_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any       (any_s)
  );

  // granted box: negative coordinates pin to 0, zero size means 1 pixel
  always_comb begin
    sel_s.x = q.req_x[grant_idx_s*COORD_W +: COORD_W];
    sel_s.y = q.req_y[grant_idx_s*COORD_W +: COORD_W];
    sel_s.w = q.req_w[grant_idx_s*SIZE_W +: SIZE_W];
    sel_s.h = q.req_h[grant_idx_s*SIZE_W +: SIZE_W];
    x_s     = sel_s.x[COORD_W-1] ? '0 : sel_s.x;
    y_s     = sel_s.y[COORD_W-1] ? '0 : sel_s.y;
    w_s     = (sel_s.w == 5'd0) ? 5'd1 : sel_s.w;
    h_s     = (sel_s.h == 5'd0) ? 5'd1 : sel_s.h;
    x_end_s = {1'b0, x_s} + {{(COORD_W+1-SIZE_W){1'b0}}, w_s} - {{COORD_W{1'b0}}, 1'b1};
    y_end_s = {1'b0, y_s} + {{(COORD_W+1-SIZE_W){1'b0}}, h_s} - {{COORD_W{1'b0}}, 1'b1};
    tx0_s   = tile_clamp({1'b0, x_s});
    tx1_s   = tile_clamp(x_end_s);
    ty0_s   = tile_clamp({1'b0, y_s});
    ty1_s   = tile_clamp(y_end_s);
  end

  // Corner walk order (tx0,ty0),(tx1,ty0),(tx0,ty1),(tx1,ty1) with degenerate
  // axes collapsed, so idx counts 0..last_idx over the distinct tiles only.
  assign last_idx_s = (multi_x_r && multi_y_r) ? 2'd3 :
                      ((multi_x_r || multi_y_r) ? 2'd1 : 2'd0);
  assign col_s = multi_x_r ? idx_r[0] : 1'b0;
  assign row_s = multi_y_r ? (multi_x_r ? idx_r[1] : idx_r[0]) : 1'b0;
  assign hit_s = rd_pend_r & map_rd_solid;

  // next-state and read strobe
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    acc_n   = acc_r | hit_s;
    rd_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        acc_n = 1'b0;
        idx_n = 2'd0;
        if (any_s) begin
          state_n = ST_ISSUE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
`ifdef SOLID_QUERY_EARLY_EXIT_EN
        if (hit_s) begin
          state_n = ST_RESP;
        end else begin
          rd_en_s = 1'b1;
          if (idx_r == last_idx_s) begin
            state_n = ST_DRAIN;
          end else begin
            idx_n = idx_r + 2'd1;
          end
        end
`else
        rd_en_s = 1'b1;
        if (idx_r == last_idx_s) begin
          state_n = ST_DRAIN;
        end else begin
          idx_n = idx_r + 2'd1;
        end
`endif
      end
      ST_DRAIN: state_n = ST_RESP;
      ST_RESP:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // state, walk index, accumulator and query latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= 2'd0;
      acc_r     <= 1'b0;
      rd_pend_r <= 1'b0;
      owner_r   <= '0;
      tx0_r     <= '0;
      tx1_r     <= '0;
      ty0_r     <= '0;
      ty1_r     <= '0;
      multi_x_r <= 1'b0;
      multi_y_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      acc_r     <= acc_n;
      rd_pend_r <= rd_en_s;
      if (accept_s) begin
        owner_r   <= grant_idx_s;
        tx0_r     <= tx0_s;
        tx1_r     <= tx1_s;
        ty0_r     <= ty0_s;
        ty1_r     <= ty1_s;
        multi_x_r <= (tx1_s != tx0_s);
        multi_y_r <= (ty1_s != ty0_s);
      end else begin
        owner_r   <= owner_r;
      end
    end
  end

  assign map_rd_en    = rd_en_s;
  assign map_rd_x     = (state_r == ST_ISSUE) ? (col_s ? tx1_r : tx0_r) : 4'd0;
  assign map_rd_y     = (state_r == ST_ISSUE) ? (row_s ? ty1_r : ty0_r) : 4'd0;
  assign busy         = (state_r != ST_IDLE);
  assign q.req_ready  = accept_s ? grant_s : '0;
  assign q.resp_valid = (state_r == ST_RESP) ? (N_REQ'(1) << owner_r) : '0;
  assign q.resp_solid = (state_r == ST_RESP) ? acc_r : 1'b0;
endmodule

// File: tb/tb_solid_query_arbiter.sv
// Directed self-checking bench for solid_query_arbiter with a registered
// tile-map model and a cycle-stamped event log.
module tb_solid_query_arbiter;
  import solid_query_arbiter_pkg::*;

  localparam int N = 4;
`ifdef SOLID_QUERY_EARLY_EXIT_EN
  localparam int EARLY_READS = 1;
  localparam int EARLY_LAT   = 3;
`else
  localparam int EARLY_READS = 4;
  localparam int EARLY_LAT   = 6;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       map_rd_en;
  logic [3:0] map_rd_x, map_rd_y;
  logic       map_rd_solid = 1'b0;
  logic       busy;

  solid_query_arbiter_if #(.N_REQ(N)) q_if ();

  solid_query_arbiter #(.N_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .q            (q_if),
    .map_rd_en    (map_rd_en),
    .map_rd_x     (map_rd_x),
    .map_rd_y     (map_rd_y),
    .map_rd_solid (map_rd_solid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic solid_map [16][16];   // [row][col]

  int         rd_cyc_q[$];
  logic [3:0] rd_x_q[$];
  logic [3:0] rd_y_q[$];
  int         acc_cyc_q[$];
  logic [3:0] acc_val_q[$];
  int         resp_cyc_q[$];
  logic [3:0] resp_val_q[$];
  logic       resp_sol_q[$];

  always @(posedge clk) map_rd_solid <= (map_rd_en === 1'b1) ? solid_map[map_rd_y][map_rd_x] : 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (map_rd_en === 1'b1) begin
      rd_cyc_q.push_back(cyc); rd_x_q.push_back(map_rd_x); rd_y_q.push_back(map_rd_y);
    end
    if (q_if.req_ready != 4'd0) begin
      acc_cyc_q.push_back(cyc); acc_val_q.push_back(q_if.req_ready);
    end
    if (q_if.resp_valid != 4'd0) begin
      resp_cyc_q.push_back(cyc); resp_val_q.push_back(q_if.resp_valid);
      resp_sol_q.push_back(q_if.resp_solid);
    end
  end

  task automatic clear_logs();
    rd_cyc_q.delete(); rd_x_q.delete(); rd_y_q.delete();
    acc_cyc_q.delete(); acc_val_q.delete();
    resp_cyc_q.delete(); resp_val_q.delete(); resp_sol_q.delete();
  endtask

  task automatic set_box(input int r, input logic [15:0] x, input logic [15:0] y,
                         input logic [4:0] w, input logic [4:0] h);
    q_if.req_x[r*16 +: 16] = x;
    q_if.req_y[r*16 +: 16] = y;
    q_if.req_w[r*5 +: 5]   = w;
    q_if.req_h[r*5 +: 5]   = h;
  endtask

  // Raise req r (plus any extra lines), drop r after accept, wait for the response.
  task automatic run_query(input int r, input logic [15:0] x, input logic [15:0] y,
                           input logic [4:0] w, input logic [4:0] h,
                           input logic [3:0] extra, output bit timed_out);
    int n;
    clear_logs();
    @(posedge clk); #1;
    set_box(r, x, y, w, h);
    q_if.req_valid = q_if.req_valid | extra;
    q_if.req_valid[r] = 1'b1;
    n = 0;
    while (acc_cyc_q.size() == 0 && n < 40) begin @(posedge clk); n++; end
    #1 q_if.req_valid[r] = 1'b0;
    while (resp_cyc_q.size() == 0 && n < 40) begin @(posedge clk); n++; end
    timed_out = (n >= 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (map_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", map_rd_en); end
    n_checks++; if ({map_rd_x, map_rd_y} !== 8'h00) begin n_fail++; $display("FAIL reset_rd_xy: got %h want 00", {map_rd_x, map_rd_y}); end
    n_checks++; if (q_if.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", q_if.req_ready); end
    n_checks++; if (q_if.resp_valid !== 4'b0000 || q_if.resp_solid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: got %b/%b want 0000/0", q_if.resp_valid, q_if.resp_solid); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit to; int a;
    run_query(0, 16'd8, 16'd32, 5'd8, 5'd8, 4'b0000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout want response"); return; end
    a = acc_cyc_q[0];
    n_checks++; if (acc_val_q[0] !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", acc_val_q[0]); end
    n_checks++; if (rd_cyc_q.size() !== 1) begin n_fail++; $display("FAIL single_nreads: got %0d want 1", rd_cyc_q.size()); end
    else begin
      n_checks++; if ({rd_x_q[0], rd_y_q[0]} !== {4'd1, 4'd4} || rd_cyc_q[0] !== a + 1) begin
        n_fail++; $display("FAIL single_read: got (%0d,%0d)@+%0d want (1,4)@+1", rd_x_q[0], rd_y_q[0], rd_cyc_q[0] - a); end
    end
    n_checks++; if (resp_cyc_q[0] !== a + 3) begin n_fail++; $display("FAIL single_latency: got +%0d want +3", resp_cyc_q[0] - a); end
    n_checks++; if (resp_val_q[0] !== 4'b0001 || resp_sol_q[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_resp: got %b/%b want 0001/0", resp_val_q[0], resp_sol_q[0]); end
  endtask

  task automatic test_four_corner();
    bit to; int a;
    logic [3:0] ex [4];
    logic [3:0] ey [4];
    ex = '{4'd1, 4'd2, 4'd1, 4'd2};
    ey = '{4'd4, 4'd4, 4'd5, 4'd5};
    run_query(1, 16'd12, 16'd36, 5'd8, 5'd8, 4'b0000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL four_timeout: got timeout want response"); return; end
    a = acc_cyc_q[0];
    n_checks++; if (rd_cyc_q.size() !== 4) begin n_fail++; $display("FAIL four_nreads: got %0d want 4", rd_cyc_q.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if ({rd_x_q[k], rd_y_q[k]} !== {ex[k], ey[k]} || rd_cyc_q[k] !== a + 1 + k) begin
          n_fail++; $display("FAIL four_read%0d: got (%0d,%0d)@+%0d want (%0d,%0d)@+%0d",
                             k, rd_x_q[k], rd_y_q[k], rd_cyc_q[k] - a, ex[k], ey[k], k + 1); end
      end
    end
    n_checks++; if (resp_cyc_q[0] !== a + 6 || resp_val_q[0] !== 4'b0010 || resp_sol_q[0] !== 1'b0) begin
      n_fail++; $display("FAIL four_resp: got +%0d %b/%b want +6 0010/0", resp_cyc_q[0] - a, resp_val_q[0], resp_sol_q[0]); end
  endtask

  task automatic test_early_solid();
    bit to; int a;
    run_query(2, 16'd4, 16'd36, 5'd8, 5'd8, 4'b0000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL early_timeout: got timeout want response"); return; end
    a = acc_cyc_q[0];
    n_checks++; if (rd_cyc_q.size() !== EARLY_READS) begin n_fail++; $display("FAIL early_nreads: got %0d want %0d", rd_cyc_q.size(), EARLY_READS); end
    n_checks++; if (resp_cyc_q[0] !== a + EARLY_LAT) begin n_fail++; $display("FAIL early_latency: got +%0d want +%0d", resp_cyc_q[0] - a, EARLY_LAT); end
    n_checks++; if (resp_val_q[0] !== 4'b0100 || resp_sol_q[0] !== 1'b1) begin
      n_fail++; $display("FAIL early_resp: got %b/%b want 0100/1", resp_val_q[0], resp_sol_q[0]); end
  endtask

  task automatic test_clamp();
    bit to;
    run_query(3, 16'hFFF8, 16'd40, 5'd8, 5'd8, 4'b0000, to);
    n_checks++; if (to || rd_cyc_q.size() !== 1) begin n_fail++; $display("FAIL clamp_neg_nreads: got %0d want 1", rd_cyc_q.size()); end
    else begin
      n_checks++; if ({rd_x_q[0], rd_y_q[0]} !== {4'd0, 4'd5} || resp_sol_q[0] !== 1'b1) begin
        n_fail++; $display("FAIL clamp_neg: got (%0d,%0d) solid %b want (0,5) solid 1", rd_x_q[0], rd_y_q[0], resp_sol_q[0]); end
    end
    run_query(3, 16'd124, 16'd0, 5'd8, 5'd8, 4'b0000, to);
    n_checks++; if (to || rd_cyc_q.size() !== 1) begin n_fail++; $display("FAIL clamp_sat_nreads: got %0d want 1", rd_cyc_q.size()); end
    else begin
      n_checks++; if ({rd_x_q[0], rd_y_q[0]} !== {4'd15, 4'd0} || resp_sol_q[0] !== 1'b1) begin
        n_fail++; $display("FAIL clamp_sat: got (%0d,%0d) solid %b want (15,0) solid 1", rd_x_q[0], rd_y_q[0], resp_sol_q[0]); end
    end
  endtask

  task automatic test_arbitration();
    int n;
    logic [3:0] want;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) set_box(i, 16'(8 * i), 16'd0, 5'd8, 5'd8);
    q_if.req_valid = 4'b1111;
    n = 0;
    while (acc_cyc_q.size() < 5 && n < 100) begin @(posedge clk); n++; end
    #1 q_if.req_valid = 4'b0000;
    while (resp_cyc_q.size() < 5 && n < 100) begin @(posedge clk); n++; end
    n_checks++; if (n >= 100) begin n_fail++; $display("FAIL arb_timeout: got %0d grants want 5", acc_cyc_q.size()); return; end
    for (int k = 0; k < 5; k++) begin
      want = 4'b0001 << (k % 4);
      n_checks++; if (acc_val_q[k] !== want || resp_val_q[k] !== want) begin
        n_fail++; $display("FAIL arb_order%0d: got grant %b resp %b want %b", k, acc_val_q[k], resp_val_q[k], want); end
      n_checks++; if (resp_sol_q[k] !== ((k % 4) == 2) || resp_cyc_q[k] !== acc_cyc_q[k] + 3) begin
        n_fail++; $display("FAIL arb_resp%0d: got solid %b at +%0d want %b at +3", k, resp_sol_q[k],
                           resp_cyc_q[k] - acc_cyc_q[k], (k % 4) == 2); end
      if (k < 4) begin
        n_checks++; if (acc_cyc_q[k+1] < resp_cyc_q[k] + 1) begin
          n_fail++; $display("FAIL arb_gap%0d: got next grant at %0d want >= %0d", k, acc_cyc_q[k+1], resp_cyc_q[k] + 1); end
      end
    end
  endtask

  task automatic test_reset_mid_query();
    int n;
    bit to;
    clear_logs();
    @(posedge clk); #1;
    set_box(0, 16'd12, 16'd36, 5'd8, 5'd8);
    q_if.req_valid[0] = 1'b1;
    n = 0;
    while (acc_cyc_q.size() == 0 && n < 40) begin @(posedge clk); n++; end
    #1 q_if.req_valid[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || map_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy %b rd_en %b want 0 0", busy, map_rd_en); end
    repeat (8) @(posedge clk);
    n_checks++; if (resp_cyc_q.size() !== 0 || rd_cyc_q.size() !== 2) begin
      n_fail++; $display("FAIL midrst_abandon: got %0d resp %0d reads want 0 resp 2 reads", resp_cyc_q.size(), rd_cyc_q.size()); end
    set_box(1, 16'd8, 16'd0, 5'd8, 5'd8);
    run_query(0, 16'd8, 16'd32, 5'd8, 5'd8, 4'b0010, to);
    #1 q_if.req_valid = 4'b0000;
    n_checks++; if (to || acc_val_q[0] !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_pointer: got grant %b want 0001", acc_val_q[0]); end
    else begin
      n_checks++; if (resp_val_q[0] !== 4'b0001 || resp_sol_q[0] !== 1'b0 || resp_cyc_q[0] !== acc_cyc_q[0] + 3) begin
        n_fail++; $display("FAIL midrst_after: got %b/%b at +%0d want 0001/0 at +3", resp_val_q[0], resp_sol_q[0],
                           resp_cyc_q[0] - acc_cyc_q[0]); end
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) solid_map[r][c] = 1'b0;
    solid_map[4][0]  = 1'b1;
    solid_map[5][0]  = 1'b1;
    solid_map[0][15] = 1'b1;
    solid_map[0][2]  = 1'b1;
    q_if.req_valid = '0;
    q_if.req_x = '0; q_if.req_y = '0; q_if.req_w = '0; q_if.req_h = '0;
    test_reset();
    test_single();
    test_four_corner();
    test_early_solid();
    test_clamp();
    test_arbitration();
    test_reset_mid_query();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/solid_query_arbiter.md
Name: solid_query_arbiter

Overview:
- Shares the single tile-map solidity read port between N gameplay requesters (player, spring, balloon, falling-block objects); each request is a pixel-space collision box.
- Per granted query, sequences the 1–4 tile lookups that the box overlaps, clamps coordinates to the 16x16 map, and returns one solid/not-solid bit.
- Sits between the object update FSMs and the map ROM.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- COORD_W, 16, pixel coordinate width, two's complement
- TILE_SHIFT, 3, log2 of tile size in pixels (8 px tiles)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester query pending; held until accepted
- req_ready  out  N_REQ  one-hot pulse: query of requester i accepted this cycle
- req_x  in  N_REQ*COORD_W  box left pixel, signed
- req_y  in  N_REQ*COORD_W  box top pixel, signed
- req_w  in  N_REQ*5  box width in pixels, 1..16
- req_h  in  N_REQ*5  box height in pixels, 1..16
- map_rd_en  out  1  map read strobe
- map_rd_x  out  4  tile column
- map_rd_y  out  4  tile row
- map_rd_solid  in  1  solid flag; valid exactly one cycle after map_rd_en
- resp_valid  out  N_REQ  one-hot, single-cycle result pulse to the owning requester
- resp_solid  out  1  result; meaningful only while resp_valid != 0
- busy  out  1  query in flight (state != IDLE)

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_solid=0, map_rd_en=0, map_rd_x=0, map_rd_y=0, busy=0, round-robin pointer=0, state=IDLE.
- States: IDLE -> ISSUE -> DRAIN -> RESP -> IDLE.
- IDLE: if any req_valid, grant the first set bit at or after the pointer (wrapping); pulse req_ready[i]; latch x, y, w, h, owner index; pointer <= i+1 mod N_REQ; go to ISSUE next cycle.
- Latch-time arithmetic:
  - x or y with bit 15 set is forced to 0.
  - w or h equal to 0 is treated as 1.
  - Tile indices: tx0 = x>>3, tx1 = (x+w-1)>>3, ty0 = y>>3, ty1 = (y+h-1)>>3, computed 17-bit with no overflow.
  - Any tile index > 15 saturates to 15.
  - Corner list in order (tx0,ty0), (tx1,ty0), (tx0,ty1), (tx1,ty1), with entries skipped when tx1==tx0 or ty1==ty0. Count is 1, 2 or 4.
- ISSUE: one map_rd_en per cycle, back-to-back, one per corner. On the last corner go to DRAIN.
- DRAIN: OR each returning map_rd_solid into an accumulator; when the last read data returns, go to RESP.
- RESP: resp_valid[owner]=1 and resp_solid=accumulator for exactly one cycle; go to IDLE. No grant is made in the RESP cycle.
- Latency from the accept cycle A:
  - 1 corner: read A+1, response A+3.
  - 4 corners: reads A+1..A+4, response A+6.
  - Next grant no earlier than response+1.
- Requests arriving while busy wait; req_valid dropped before acceptance is simply not served.
- A simultaneous req_valid on every line with pointer p yields grant order p, p+1, ... (fairness).
- rst asserted mid-query: the in-flight query is abandoned with no resp_valid, all outputs return to reset values next cycle, and late map data is ignored.

Optional Feature:
- Macro: SOLID_QUERY_EARLY_EXIT_EN.
- Defined: the first returning map_rd_solid=1 stops further map_rd_en that cycle, moves straight to RESP the following cycle, and discards any one read still in flight. Latency is variable.
- Undefined: every corner is always read and latency is fixed by corner count.

Decomposition:
- Shared package additions:
  - solid_query_t packed struct {x, y, w, h}
  - MAP_TILES=16 and TILE_SHIFT=3 constants
  - Tile-clamp helper function
- Sub-module: rr_arbiter (N_REQ-wide round-robin grant with a pointer advanced on accept); reusable elsewhere.

Test Plan:
- Single query from req0: x=8, y=32, w=8, h=8 -> 1 read at tile (1,4); resp_valid=0001 at A+3; resp_solid=0.
- Query x=12, y=36, w=8, h=8 -> reads (1,4), (2,4), (1,5), (2,5) at A+1..A+4; resp_solid=0 at A+6.
- Query x=4, y=36, w=8, h=8 -> tile (0,4) solid, resp_solid=1.
  - EARLY_EXIT defined: exactly 1 map_rd_en, response at A+3.
  - EARLY_EXIT undefined: 4 reads, response at A+6.
- Clamping: x=16'hFFF8, y=40, w=8, h=8 -> read (0,5), resp_solid=1. x=124, y=0, w=8, h=8 -> tx1 saturates to 15, single column, read (15,0), resp_solid=1.
- Arbitration: after reset, req_valid=1111 held -> grants 0,1,2,3,0 in order; each grant follows the prior resp_valid by ≥1 cycle; responses go to the matching one-hot bit.
- Reset mid-query: assert rst at A+2 of a 4-corner query -> no resp_valid, busy=0 and map_rd_en=0 the cycle after rst; a subsequent query completes normally with pointer=0.
